// File: rtl/mem_copy_dma_pkg.sv
// Shared definitions for the word-copy DMA engine.
// Holds the FSM state encoding, the word size and the byte-address helper.
package mem_copy_dma_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RD   = 2'd1;
   localparam logic [1:0] ST_WR   = 2'd2;
   localparam logic [1:0] ST_FIN  = 2'd3;

   localparam logic [31:0] WORD_BYTES = 32'd4;

   // Byte address of word idx from base; wraps modulo 2^32, low bits untouched.
   function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
      return base + (idx * WORD_BYTES);
   endfunction

endpackage

// File: rtl/mem_copy_dma.sv
// Word-at-a-time memory copy engine: alternating read/write cycles against an
// external combinational-read memory, with abort, progress count and checksum.
module mem_copy_dma
   import mem_copy_dma_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [31:0]      srcAddr,
   input  logic [31:0]      dstAddr,
   input  logic [CNT_W-1:0] wordCount,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [CNT_W-1:0] wordsDone,
   output logic [31:0]      checksum,
   output logic [31:0]      address,
   output logic [31:0]      writeData,
   output logic             memWrite,
   input  logic [31:0]      readData
);

   logic [1:0]       state_r, state_s;
   logic [31:0]      src_r, src_s;
   logic [31:0]      dst_r, dst_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [CNT_W-1:0] words_r, words_s;
   logic [31:0]      sum_r, sum_s;
   logic [31:0]      hold_r, hold_s;
   logic             aborted_r, aborted_s;

   logic             busy_r, busy_s;
   logic             done_r, done_s;
   logic [31:0]      addr_r, addr_s;
   logic [31:0]      wdata_r, wdata_s;
   logic             mwe_r, mwe_s;

   // Next-state and datapath update for the copy sequencer.
   always_comb begin
      state_s   = state_r;
      src_s     = src_r;
      dst_s     = dst_r;
      cnt_s     = cnt_r;
      words_s   = words_r;
      sum_s     = sum_r;
      hold_s    = hold_r;
      aborted_s = aborted_r;
      case (state_r)
         ST_IDLE: begin
            // abort is deliberately not looked at here: start wins.
            if (start) begin
               src_s     = srcAddr;
               dst_s     = dstAddr;
               cnt_s     = wordCount;
               words_s   = {CNT_W{1'b0}};
               sum_s     = 32'd0;
               aborted_s = 1'b0;
               if (wordCount == {CNT_W{1'b0}}) begin
                  state_s = ST_FIN;
               end else begin
                  state_s = ST_RD;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RD: begin
            hold_s = readData;
            if (abort) begin
               state_s   = ST_FIN;
               aborted_s = 1'b1;
            end else begin
               state_s = ST_WR;
            end
         end
         ST_WR: begin
            // The write in flight always completes and is counted, abort or not.
            words_s = words_r + CNT_W'(1);
            sum_s   = sum_r + hold_r;
            if (abort) begin
               state_s   = ST_FIN;
               aborted_s = 1'b1;
            end else if (words_s == cnt_r) begin
               state_s = ST_FIN;
            end else begin
               state_s = ST_RD;
            end
         end
         ST_FIN: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Output values for the state being entered, so the registered outputs line up with it.
   always_comb begin
      busy_s  = (state_s == ST_RD) || (state_s == ST_WR);
      done_s  = (state_s == ST_FIN);
      addr_s  = 32'd0;
      wdata_s = 32'd0;
      mwe_s   = 1'b0;
      case (state_s)
         ST_RD: begin
            addr_s = word_addr(src_s, 32'(words_s));
         end
         ST_WR: begin
            addr_s  = word_addr(dst_s, 32'(words_s));
            wdata_s = hold_s;
            mwe_s   = 1'b1;
         end
         default: begin
            addr_s  = 32'd0;
            wdata_s = 32'd0;
            mwe_s   = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         src_r     <= 32'd0;
         dst_r     <= 32'd0;
         cnt_r     <= {CNT_W{1'b0}};
         words_r   <= {CNT_W{1'b0}};
         sum_r     <= 32'd0;
         hold_r    <= 32'd0;
         aborted_r <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         addr_r    <= 32'd0;
         wdata_r   <= 32'd0;
         mwe_r     <= 1'b0;
      end else begin
         state_r   <= state_s;
         src_r     <= src_s;
         dst_r     <= dst_s;
         cnt_r     <= cnt_s;
         words_r   <= words_s;
         sum_r     <= sum_s;
         hold_r    <= hold_s;
         aborted_r <= aborted_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
         addr_r    <= addr_s;
         wdata_r   <= wdata_s;
         mwe_r     <= mwe_s;
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign aborted   = aborted_r;
   assign wordsDone = words_r;
   assign checksum  = sum_r;
   assign address   = addr_r;
   assign writeData = wdata_r;
   assign memWrite  = mwe_r;

endmodule
